// File: rtl/prefetch_queue.sv
// prefetch_queue: byte-serial instruction prefetch FIFO between the byte-wide
// program RAM and the fetch/decode logic. Streams sequential bytes into a
// DEPTH-entry FIFO and presents the four oldest bytes plus their address.
// Optional feature macro: PFQ_PROTO_CHECK_EN (flags illegal consume and clamps the pop).
module prefetch_queue #(
    parameter int          DEPTH    = 8,
    parameter int          AW       = 10,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [31:0]                flush_pc,
    input  logic                       mem_busy,
    output logic                       mem_en,
    output logic [AW-1:0]              mem_addr,
    input  logic [7:0]                 mem_dout,
    output logic [31:0]                q_bytes,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic [31:0]                q_pc,
    input  logic [2:0]                 consume,
    output logic                       proto_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    fifo_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   head_pc_q, head_pc_d;
    logic          pending_q, pending_d;
    logic          perr_q, perr_d;

    logic [CW:0]   occ;
    logic          issue;
    logic [2:0]    pop;
    logic          illegal;

    // Issue a read whenever the FIFO has room for the byte plus the one in flight.
    always_comb begin
        occ   = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
        issue = rst && !flush && !mem_busy && (occ < (CW+1)'(DEPTH));
    end

    assign mem_en   = issue;
    assign mem_addr = fetch_pc_q[AW-1:0];

`ifdef PFQ_PROTO_CHECK_EN
    logic [2:0] pop_max;

    // Illegal consume is flagged and the pop limited to what is actually present.
    always_comb begin
        pop_max = (count_q > CW'(4)) ? 3'd4 : count_q[2:0];
        illegal = (CW'(consume) > count_q) || (consume > 3'd4);
        pop     = illegal ? pop_max : consume;
    end
`else
    assign illegal = 1'b0;
    assign pop     = consume;
`endif

    // Next-state: flush restarts everything at flush_pc; otherwise pop, capture, issue.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        pending_d  = 1'b0;
        perr_d     = perr_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = flush_pc;
            head_pc_d  = flush_pc;
            perr_d     = 1'b0;
        end else begin
            count_d   = count_q + CW'(pending_q) - CW'(pop);
            rd_ptr_d  = rd_ptr_q + PW'(pop);
            head_pc_d = head_pc_q + 32'(pop);
            if (pending_q) wr_ptr_d = wr_ptr_q + PW'(1);
            pending_d = issue;
            if (issue) fetch_pc_d = fetch_pc_q + 32'd1;
            perr_d    = perr_q | illegal;
        end
    end

    // Control and pointer registers; reset drops queued data and the in-flight read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            pending_q  <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            pending_q  <= pending_d;
            perr_q     <= perr_d;
        end
    end

    // Byte storage: capture the RAM response one edge after its read; a flush discards it.
    always_ff @(posedge clk) begin
        if (pending_q && !flush) fifo_q[wr_ptr_q] <= mem_dout;
    end

    // Head window: the four oldest bytes, lanes beyond count read as zero.
    always_comb begin
        q_bytes = '0;
        for (int i = 0; i < 4; i++) begin
            if (CW'(i) < count_q) q_bytes[8*i +: 8] = fifo_q[rd_ptr_q + PW'(i)];
        end
    end

    assign q_count   = count_q;
    assign q_pc      = head_pc_q;
    assign proto_err = perr_q;

endmodule
